// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the front-end: bubble encoding, register field
// positions and the IF/ID register layout.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  // addi x0,x0,0 -- architecturally a no-op, used to fill IF/ID on bubbles
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  // Extract a 5-bit register specifier starting at bit lsb
  function automatic logic [REG_W-1:0] reg_field(input logic [XLEN-1:0] instr,
                                                 input int lsb);
    return instr[lsb +: REG_W];
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
  import riscv_pkg::CNT_MAX;
(
  input  logic        clk,
  input  logic        i_clear,
  input  logic        i_enable,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  // Clear wins over enable; increment only below the ceiling
  always_ff @(posedge clk) begin
    if (i_clear)
      r_count <= '0;
    else if (i_enable && (r_count != CNT_MAX))
      r_count <= r_count + 16'd1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_stage.sv
// Fetch PC register plus IF/ID pipeline register with redirect, load-use
// stall and imem wait handling. imem_addr comes straight from the PC flop.
module if_id_stage
  import riscv_pkg::XLEN, riscv_pkg::REG_W, riscv_pkg::RS1_LSB,
         riscv_pkg::RS2_LSB, riscv_pkg::RD_LSB, riscv_pkg::ifid_t,
         riscv_pkg::reg_field;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             imem_valid,
  output logic [XLEN-1:0]  pc_IF_ID,
  output logic [XLEN-1:0]  instr_IF_ID,
  output logic             valid_IF_ID,
  output logic [REG_W-1:0] rs1_IF_ID,
  output logic [REG_W-1:0] rs2_IF_ID,
  output logic [REG_W-1:0] rd_IF_ID,
  output logic             bubble_ID_EX,
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count,
  output logic             misalign_err
);

  localparam ifid_t BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

  logic [XLEN-1:0] r_pc;
  ifid_t           r_ifid;
  logic            r_misalign;

  logic [XLEN-1:0] w_pc_nxt;
  ifid_t           w_ifid_nxt;
  logic            w_misalign_nxt;
  logic            w_stall_evt;
  logic            w_flush_evt;

  // Next-state mux: redirect > stall > imem wait > advance (reset in the flop)
  always_comb begin
    w_pc_nxt       = r_pc;
    w_ifid_nxt     = r_ifid;
    w_misalign_nxt = r_misalign;
    if (branch_taken) begin
      w_pc_nxt       = {branch_target[XLEN-1:2], 2'b00};
      w_ifid_nxt     = BUBBLE;
      w_misalign_nxt = r_misalign | (|branch_target[1:0]);
    end else if (stall) begin
      w_pc_nxt   = r_pc;
      w_ifid_nxt = r_ifid;
    end else if (!imem_valid) begin
      w_pc_nxt   = r_pc;
      w_ifid_nxt = BUBBLE;
    end else begin
      // PC+4 wraps naturally at 2^32
      w_pc_nxt         = r_pc + 32'd4;
      w_ifid_nxt.pc    = r_pc;
      w_ifid_nxt.instr = imem_rdata;
      w_ifid_nxt.valid = 1'b1;
    end
  end

  // PC, IF/ID and sticky misalign state; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_ifid     <= BUBBLE;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_ifid     <= w_ifid_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // A stall that coincides with a redirect is not counted as a stall
  assign w_stall_evt = stall & ~branch_taken;
  assign w_flush_evt = branch_taken;

  sat_counter16 u_stall_cnt (
    .clk      (clk),
    .i_clear  (reset),
    .i_enable (w_stall_evt),
    .o_count  (stall_count)
  );

  sat_counter16 u_flush_cnt (
    .clk      (clk),
    .i_clear  (reset),
    .i_enable (w_flush_evt),
    .o_count  (flush_count)
  );

  assign imem_addr    = r_pc;
  assign pc_IF_ID     = r_ifid.pc;
  assign instr_IF_ID  = r_ifid.instr;
  assign valid_IF_ID  = r_ifid.valid;
  // Decoded from the registered instruction so bubbles give x0/x0/x0
  assign rs1_IF_ID    = reg_field(r_ifid.instr, RS1_LSB);
  assign rs2_IF_ID    = reg_field(r_ifid.instr, RS2_LSB);
  assign rd_IF_ID     = reg_field(r_ifid.instr, RD_LSB);
  assign bubble_ID_EX = stall | branch_taken;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: every driven cycle pushes the expected
// post-edge outputs, which each test pops and compares after the edge.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, imem_valid;
  logic [31:0] branch_target, imem_rdata, imem_addr;
  logic [31:0] pc_IF_ID, instr_IF_ID;
  logic        valid_IF_ID, bubble_ID_EX, misalign_err;
  logic [4:0]  rs1_IF_ID, rs2_IF_ID, rd_IF_ID;
  logic [15:0] stall_count, flush_count;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc_IF_ID(pc_IF_ID),
    .instr_IF_ID(instr_IF_ID), .valid_IF_ID(valid_IF_ID),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID), .rd_IF_ID(rd_IF_ID),
    .bubble_ID_EX(bubble_ID_EX), .stall_count(stall_count),
    .flush_count(flush_count), .misalign_err(misalign_err)
  );

  typedef struct packed {
    logic [31:0] pc, pc_ifid, instr;
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] sc, fc;
    logic        mis;
  } obs_t;

  obs_t sb[$];
  obs_t got, exp_o;
  int   checks = 0, failures = 0;

  // Reference state of the stage
  logic [31:0] m_pc, m_pc_ifid, m_instr;
  logic        m_valid, m_mis;
  logic [15:0] m_sc, m_fc;

  function automatic obs_t dut_obs();
    return '{pc: imem_addr, pc_ifid: pc_IF_ID, instr: instr_IF_ID,
             valid: valid_IF_ID, rs1: rs1_IF_ID, rs2: rs2_IF_ID, rd: rd_IF_ID,
             sc: stall_count, fc: flush_count, mis: misalign_err};
  endfunction

  // Drive one cycle of inputs and push the outputs expected after the edge
  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [31:0] t, input logic v, input logic [31:0] d);
    obs_t e;
    reset = r; stall = s; branch_taken = b; branch_target = t;
    imem_valid = v; imem_rdata = d;
    if (r) begin
      m_pc = 32'h0; m_pc_ifid = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
      m_sc = 16'h0; m_fc = 16'h0; m_mis = 1'b0;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00}; m_pc_ifid = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      if (t[1:0] != 2'b00) m_mis = 1'b1;
    end else if (s) begin
      if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    end else if (!v) begin
      m_pc_ifid = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
    end else begin
      m_pc_ifid = m_pc; m_instr = d; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    e = '{pc: m_pc, pc_ifid: m_pc_ifid, instr: m_instr, valid: m_valid,
          rs1: m_instr[19:15], rs2: m_instr[24:20], rd: m_instr[11:7],
          sc: m_sc, fc: m_fc, mis: m_mis};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b1, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      got = dut_obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin failures++; $display("FAIL reset_sb got=%h exp=%h", got, exp_o); end
    end
    checks++;
    if ({imem_addr, valid_IF_ID, instr_IF_ID, stall_count, flush_count, misalign_err}
        !== {32'h0, 1'b0, 32'h13, 16'h0, 16'h0, 1'b0}) begin
      failures++; $display("FAIL reset_state pc=%h v=%b instr=%h sc=%h fc=%h mis=%b",
                           imem_addr, valid_IF_ID, instr_IF_ID, stall_count, flush_count, misalign_err);
    end
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00A0_0093);
      @(posedge clk); #1;
      got = dut_obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin failures++; $display("FAIL fetch_sb got=%h exp=%h", got, exp_o); end
    end
    checks++;
    if ({imem_addr, pc_IF_ID, rs1_IF_ID, rd_IF_ID, valid_IF_ID} !== {32'h0C, 32'h08, 5'd0, 5'd1, 1'b1}) begin
      failures++; $display("FAIL fetch3 pc=%h pc_ifid=%h rs1=%0d rd=%0d v=%b",
                           imem_addr, pc_IF_ID, rs1_IF_ID, rd_IF_ID, valid_IF_ID);
    end
  endtask

  task automatic test_stall();
    // One more fetch brings PC to 0x10, IF/ID holds PC 0x0C
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0031_0233);
    @(posedge clk); #1;
    got = dut_obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin failures++; $display("FAIL stall_pre_sb got=%h exp=%h", got, exp_o); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
      #1; checks++;
      if (bubble_ID_EX !== 1'b1) begin failures++; $display("FAIL stall_bubble got=%b exp=1", bubble_ID_EX); end
      @(posedge clk); #1;
      got = dut_obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin failures++; $display("FAIL stall_sb got=%h exp=%h", got, exp_o); end
      checks++;
      if ({imem_addr, pc_IF_ID, instr_IF_ID} !== {32'h10, 32'h0C, 32'h0031_0233}) begin
        failures++; $display("FAIL stall_hold pc=%h pc_ifid=%h instr=%h", imem_addr, pc_IF_ID, instr_IF_ID);
      end
    end
    checks++;
    if (stall_count !== 16'd2) begin failures++; $display("FAIL stall_count got=%0d exp=2", stall_count); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
    #1; checks++;
    if (bubble_ID_EX !== 1'b0) begin failures++; $display("FAIL stall_nobubble got=%b exp=0", bubble_ID_EX); end
    @(posedge clk); #1;
    got = dut_obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin failures++; $display("FAIL stall_resume_sb got=%h exp=%h", got, exp_o); end
    checks++;
    if (imem_addr !== 32'h14) begin failures++; $display("FAIL stall_resume pc=%h exp=00000014", imem_addr); end
  endtask

  task automatic test_branch_stall();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h1234_5678);
    @(posedge clk); #1;
    got = dut_obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin failures++; $display("FAIL branch_sb got=%h exp=%h", got, exp_o); end
    checks++;
    if ({imem_addr, valid_IF_ID, instr_IF_ID, flush_count, stall_count}
        !== {32'h200, 1'b0, 32'h13, 16'd1, 16'd2}) begin
      failures++; $display("FAIL branch_stall pc=%h v=%b instr=%h fc=%0d sc=%0d",
                           imem_addr, valid_IF_ID, instr_IF_ID, flush_count, stall_count);
    end
  endtask

  task automatic test_misalign();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b1, 32'h0);
    @(posedge clk); #1;
    got = dut_obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin failures++; $display("FAIL misalign_sb got=%h exp=%h", got, exp_o); end
    checks++;
    if ({imem_addr, misalign_err} !== {32'h200, 1'b1}) begin
      failures++; $display("FAIL misalign pc=%h mis=%b exp pc=00000200 mis=1", imem_addr, misalign_err);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013 | (i << 7));
      @(posedge clk); #1;
      got = dut_obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin failures++; $display("FAIL misalign_run_sb got=%h exp=%h", got, exp_o); end
    end
    checks++;
    if (misalign_err !== 1'b1) begin failures++; $display("FAIL misalign_sticky got=%b exp=1", misalign_err); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    @(posedge clk); #1;
    got = dut_obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin failures++; $display("FAIL misalign_rst_sb got=%h exp=%h", got, exp_o); end
    checks++;
    if (misalign_err !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", misalign_err); end
  endtask

  task automatic test_imem_wait_wrap();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0113);
    @(posedge clk); #1;
    got = dut_obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin failures++; $display("FAIL wait_pre_sb got=%h exp=%h", got, exp_o); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      got = dut_obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin failures++; $display("FAIL wait_sb got=%h exp=%h", got, exp_o); end
      checks++;
      if ({imem_addr, valid_IF_ID} !== {32'h04, 1'b0}) begin
        failures++; $display("FAIL wait_hold pc=%h v=%b exp pc=00000004 v=0", imem_addr, valid_IF_ID);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    @(posedge clk); #1;
    got = dut_obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin failures++; $display("FAIL wrap_br_sb got=%h exp=%h", got, exp_o); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0010_0093);
    @(posedge clk); #1;
    got = dut_obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin failures++; $display("FAIL wrap_sb got=%h exp=%h", got, exp_o); end
    checks++;
    if ({imem_addr, pc_IF_ID, misalign_err} !== {32'h0, 32'hFFFF_FFFC, 1'b0}) begin
      failures++; $display("FAIL wrap pc=%h pc_ifid=%h mis=%b", imem_addr, pc_IF_ID, misalign_err);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 65537; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      @(posedge clk); #1;
      got = dut_obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin failures++; $display("FAIL sat_sb i=%0d got=%h exp=%h", i, got, exp_o); end
    end
    checks++;
    if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h exp=ffff", stall_count); end
    // Reset during a stall, together with a redirect
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0800, 1'b1, 32'h0);
    @(posedge clk); #1;
    got = dut_obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin failures++; $display("FAIL sat_rst_sb got=%h exp=%h", got, exp_o); end
    checks++;
    if ({stall_count, flush_count, imem_addr} !== {16'h0, 16'h0, 32'h0}) begin
      failures++; $display("FAIL sat_rst sc=%h fc=%h pc=%h", stall_count, flush_count, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic r, s, b, v;
    logic [31:0] t;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 4) != 0);
      t = $urandom;
      drive(r, s, b, t, v, $urandom);
      #1; checks++;
      if (bubble_ID_EX !== (s | b)) begin failures++; $display("FAIL b2b_bubble got=%b exp=%b", bubble_ID_EX, s | b); end
      @(posedge clk); #1;
      got = dut_obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin failures++; $display("FAIL b2b_sb i=%0d got=%h exp=%h", i, got, exp_o); end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_stall();
    test_branch_stall();
    test_misalign();
    test_imem_wait_wrap();
    test_saturate();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  load-use stall from hazard detection; hold PC and IF/ID.
REQ-006 branch_taken  in  1  redirect request from EX.
REQ-007 branch_target  in  32  redirect address.
REQ-008 imem_addr  out  32  current PC to instruction memory.
REQ-009 imem_rdata  in  32  instruction for imem_addr.
REQ-010 imem_valid  in  1  imem_rdata valid this cycle.
REQ-011 pc_IF_ID  out  32  PC of the instruction held in IF/ID.
REQ-012 instr_IF_ID  out  32  instruction held in IF/ID.
REQ-013 valid_IF_ID  out  1  IF/ID holds a real instruction.
REQ-014 rs1_IF_ID, rs2_IF_ID, rd_IF_ID  out  5 each  instr_IF_ID[19:15], [24:20], [11:7].
REQ-015 bubble_ID_EX  out  1  force ID/EX control to zero; equals stall OR branch_taken, combinational.
REQ-016 stall_count, flush_count  out  16 each  saturating event counters.
REQ-017 misalign_err  out  1  sticky: a redirect target had nonzero bits [1:0].

Function
REQ-018 imem_addr SHALL equal the PC register; no combinational path from inputs to imem_addr.
REQ-019 Per-cycle priority SHALL be: reset > branch_taken > stall > !imem_valid > normal advance.
REQ-020 branch_taken: PC <= {branch_target[31:2],2'b00}; IF/ID <= bubble (instr NOP_INSTR, valid 0, pc 0); flush_count +1 (saturating).
REQ-021 branch_taken with branch_target[1:0] != 0 SHALL set misalign_err, which stays 1 until reset.
REQ-022 stall (no branch): PC, pc_IF_ID, instr_IF_ID, valid_IF_ID hold; stall_count +1 (saturating).
REQ-023 !imem_valid (no branch, no stall): PC holds; IF/ID <= bubble.
REQ-024 Normal advance: pc_IF_ID <= PC; instr_IF_ID <= imem_rdata; valid_IF_ID <= 1; PC <= PC+4.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-026 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-027 rs1/rs2/rd_IF_ID SHALL be decoded from the registered instruction only (no imem_rdata path), so a bubble yields 0/0/0.
REQ-028 Latency: an instruction accepted at edge N is visible on IF/ID outputs after edge N, held for as many cycles as stall is asserted.

Reset
REQ-029 On a rising edge with reset=1: PC <= RESET_PC; IF/ID <= bubble; counters <= 0; misalign_err <= 0; all other inputs ignored that cycle.
REQ-030 Reset asserted mid-stall or concurrently with branch_taken SHALL take precedence, with no counter increment.
REQ-031 First fetch SHALL occur on the first edge after reset deasserts.

Structure
REQ-032 Shared package riscv_pkg SHALL hold NOP_INSTR, the field bit positions (RS1/RS2/RD) and XLEN=32; the module imports them.
REQ-033 One sub-module, sat_counter16 (enable, clear, count), SHALL be instantiated twice for stall_count and flush_count.
REQ-034 All remaining logic (PC register, IF/ID register, next-state mux) SHALL be written flat in if_id_stage.

Verification
REQ-035 Reset, imem_valid=1, imem_rdata=32'h00A00093, 3 edges -> PC=0x0C, pc_IF_ID=0x08, rs1=0, rd=1, valid=1.
REQ-036 stall=1 for 2 cycles starting at PC=0x10 -> PC=0x10 and IF/ID frozen for 2 cycles, stall_count=2, bubble_ID_EX=1; advance resumes to 0x14.
REQ-037 branch_taken=1 with stall=1 and target 0x200 -> PC=0x200, valid_IF_ID=0, instr_IF_ID=0x00000013, flush_count=1, stall_count unchanged.
REQ-038 Target 0x203 -> PC=0x200, misalign_err=1, still 1 after 10 normal cycles; cleared only by reset.
REQ-039 imem_valid=0 for 3 cycles -> PC holds, valid_IF_ID=0; PC=0xFFFFFFFC then advance -> PC=0x00000000.
REQ-040 Force 65,537 stall cycles -> stall_count=16'hFFFF; reset asserted during stall -> all counters 0, PC=RESET_PC.
